// File: rtl/scoreboard_pkg.sv
// Shared types for the decode-stage issue scoreboard:
// architectural register names, issue FSM states and counter sizing.
package scoreboard_pkg;

  typedef enum logic [4:0] {
    X0,  X1,  X2,  X3,  X4,  X5,  X6,  X7,
    X8,  X9,  X10, X11, X12, X13, X14, X15,
    X16, X17, X18, X19, X20, X21, X22, X23,
    X24, X25, X26, X27, X28, X29, X30, X31
  } register_e;

  typedef enum logic {
    ISSUE_IDLE,
    ISSUE_SQUASH
  } issue_state_e;

  function automatic int count_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/scoreboard_entry.sv
// One saturating in-flight write counter for a single register.
// Underflow/overflow pulse for one cycle when saturation kicks in.
module scoreboard_entry #(
  parameter int MAX = 3,
  parameter int CW  = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  input  logic dec_a,
  input  logic dec_b,
  output logic nonzero,
  output logic full,
  output logic underflow,
  output logic overflow
);

  localparam logic [CW-1:0] MAXV = CW'(MAX);

  typedef logic [CW:0] wide_t;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [1:0]    ndec;
  wide_t         drop;

  always_comb begin
    count_d   = count_q;
    underflow = 1'b0;
    overflow  = 1'b0;
    ndec      = {1'b0, dec_a} + {1'b0, dec_b};
    drop      = wide_t'(ndec) - wide_t'(inc);
    if (clr) begin
      count_d = '0;
    end else if (inc && ndec == 2'd0) begin
      if (count_q == MAXV) overflow = 1'b1;
      else count_d = count_q + CW'(1);
    end else if (wide_t'(ndec) > wide_t'(inc)) begin
      if (wide_t'(count_q) < drop) begin
        underflow = 1'b1;
        count_d   = '0;
      end else begin
        count_d = count_q - CW'(drop);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else count_q <= count_d;
  end

  assign nonzero = |count_q;
  assign full    = (count_q == MAXV);

endmodule

// File: rtl/issue_scoreboard.sv
// Decode issue control: RAW/full stalls from per-register counters,
// early-jump redirect and wrong-path squash sequencing.
module issue_scoreboard
  import scoreboard_pkg::*;
#(
  parameter int MAX_IN_FLIGHT = 3,
  parameter int SQUASH_SLOTS  = 1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      decode_valid_i,
  input  register_e rs1_address_i,
  input  logic      rs1_used_i,
  input  register_e rs2_address_i,
  input  logic      rs2_used_i,
  input  logic      write_enable_i,
  input  register_e rd_address_i,
  input  logic      early_jump_i,
  input  logic      retire_valid_i,
  input  register_e retire_rd_address_i,
  input  logic      kill_valid_i,
  input  register_e kill_rd_address_i,
  input  logic      flush_i,
  output logic      issue_o,
  output logic      stall_o,
  output logic      squash_o,
  output logic      redirect_o,
  output logic      busy_o,
  output logic      error_o
);

  localparam int CW = count_width(MAX_IN_FLIGHT);

  issue_state_e state_q;
  issue_state_e state_d;
  logic [1:0]   rem_q;
  logic [1:0]   rem_d;
  logic         error_q;
  logic [31:0]  nz;
  logic [31:0]  full_v;
  logic [31:0]  uf_v;
  logic [31:0]  of_v;
  logic         haz1;
  logic         haz2;
  logic         full;

  // x0 is never tracked, so its slot reads as permanently empty
  assign nz[0]     = 1'b0;
  assign full_v[0] = 1'b0;
  assign uf_v[0]   = 1'b0;
  assign of_v[0]   = 1'b0;

  for (genvar r = 1; r < 32; r++) begin : g_entry
    scoreboard_entry #(
      .MAX(MAX_IN_FLIGHT),
      .CW (CW)
    ) u_entry (
      .clk      (clk_i),
      .rst_n    (rst_ni),
      .clr      (flush_i),
      .inc      (issue_o && write_enable_i &&
                 rd_address_i == register_e'(r)),
      .dec_a    (retire_valid_i &&
                 retire_rd_address_i == register_e'(r)),
      .dec_b    (kill_valid_i &&
                 kill_rd_address_i == register_e'(r)),
      .nonzero  (nz[r]),
      .full     (full_v[r]),
      .underflow(uf_v[r]),
      .overflow (of_v[r])
    );
  end

  assign haz1 = rs1_used_i && nz[rs1_address_i];
  assign haz2 = rs2_used_i && nz[rs2_address_i];
  assign full = write_enable_i && full_v[rd_address_i];

  assign squash_o   = decode_valid_i && state_q == ISSUE_SQUASH;
  assign stall_o    = decode_valid_i && !squash_o &&
                      (haz1 || haz2 || full) && !flush_i;
  assign issue_o    = decode_valid_i && !squash_o &&
                      !stall_o && !flush_i;
  assign redirect_o = issue_o && early_jump_i;
  assign busy_o     = |nz;
  assign error_o    = error_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (flush_i) begin
      state_d = ISSUE_IDLE;
      rem_d   = '0;
    end else begin
      unique case (state_q)
        ISSUE_IDLE: begin
          if (redirect_o) begin
            state_d = ISSUE_SQUASH;
            rem_d   = 2'(SQUASH_SLOTS);
          end
        end
        ISSUE_SQUASH: begin
          if (decode_valid_i) begin
            rem_d = rem_q - 2'd1;
            if (rem_q == 2'd1) state_d = ISSUE_IDLE;
          end
        end
        default: state_d = ISSUE_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ISSUE_IDLE;
      rem_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      error_q <= error_q | (|uf_v) | (|of_v);
    end
  end

endmodule
